// File: rtl/crop_pkg.sv
// crop_pkg: shared dimensions, coordinate widths and FSM encoding for the crop window controller
package crop_pkg;
    localparam int SRC_W_DEF = 1280;
    localparam int SRC_H_DEF = 720;
    localparam int WIN_W_DEF = 960;
    localparam int WIN_H_DEF = 540;
    localparam int STEP_DEF  = 16;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PEND   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
endpackage

// File: rtl/crop_axis_step.sv
// crop_axis_step: next staged coordinate for one axis (cfg clamp, pan step, saturate or wrap)
// Wrap instead of saturation when CROP_WIN_CTRL_WRAP_EN is defined.
module crop_axis_step #(
    parameter int W    = 11,
    parameter int MAX  = 320,
    parameter int STEP = 16
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] val,
    input  logic         ld,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);
    localparam logic [W:0] MAXW = (W+1)'(MAX);
    logic [W:0]   up, dn;
    logic [W-1:0] hi, lo;
    // one extra bit: dn[W] flags underflow, up > MAXW flags overflow
    assign up = {1'b0, cur} + (W+1)'(STEP);
    assign dn = {1'b0, cur} - (W+1)'(STEP);
`ifdef CROP_WIN_CTRL_WRAP_EN
    assign hi = (up > MAXW) ? '0 : up[W-1:0];
    assign lo = dn[W] ? MAXW[W-1:0] : dn[W-1:0];
`else
    assign hi = (up > MAXW) ? MAXW[W-1:0] : up[W-1:0];
    assign lo = dn[W] ? '0 : dn[W-1:0];
`endif
    always_comb begin
        nxt = ld ? ((val > MAXW[W-1:0]) ? MAXW[W-1:0] : val) :
              (inc & ~dec) ? hi :
              (dec & ~inc) ? lo : cur;
    end
endmodule

// File: rtl/crop_win_ctrl.sv
// crop_win_ctrl: pan/position controller for a crop window, committing staged moves only at vsync rise
// Optional CROP_WIN_CTRL_WRAP_EN makes pans wrap at the bounds instead of saturating.
module crop_win_ctrl
    import crop_pkg::*;
#(
    parameter int SRC_W = SRC_W_DEF,
    parameter int SRC_H = SRC_H_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int WIN_H = WIN_H_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs_in,
    input  logic          pan_left,
    input  logic          pan_right,
    input  logic          pan_up,
    input  logic          pan_down,
    input  logic          cfg_valid,
    input  logic [XW-1:0] cfg_x,
    input  logic [YW-1:0] cfg_y,
    output logic          cfg_ready,
    output logic [XW-1:0] x_start,
    output logic [XW-1:0] x_end,
    output logic [YW-1:0] y_start,
    output logic [YW-1:0] y_end,
    output logic          pending,
    output logic          update_done
);
    localparam int X_MAX = SRC_W - WIN_W;
    localparam int Y_MAX = SRC_H - WIN_H;
    logic [1:0]    state;
    logic          vs_d, vs_rise, cfg_acc, pan_en, x_req, y_req;
    logic [XW-1:0] sx, sx_nxt;
    logic [YW-1:0] sy, sy_nxt;
    assign cfg_ready = state != COMMIT;
    assign pending   = state != IDLE;
    assign vs_rise   = vs_in & ~vs_d;
    assign cfg_acc   = cfg_valid & cfg_ready;
    // pans are ignored while committing or when a cfg handshake wins the cycle
    assign pan_en    = cfg_ready & ~cfg_valid;
    assign x_req     = pan_en & (pan_left ^ pan_right);
    assign y_req     = pan_en & (pan_up ^ pan_down);
    crop_axis_step #(.W(XW), .MAX(X_MAX), .STEP(STEP)) u_x (
        .cur(sx), .val(cfg_x), .ld(cfg_acc),
        .inc(pan_en & pan_right), .dec(pan_en & pan_left), .nxt(sx_nxt)
    );
    crop_axis_step #(.W(YW), .MAX(Y_MAX), .STEP(STEP)) u_y (
        .cur(sy), .val(cfg_y), .ld(cfg_acc),
        .inc(pan_en & pan_down), .dec(pan_en & pan_up), .nxt(sy_nxt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_d        <= 1'b0;
            update_done <= 1'b0;
            sx          <= XW'(X_MAX / 2);
            sy          <= YW'(Y_MAX / 2);
            x_start     <= XW'(X_MAX / 2);
            x_end       <= XW'(X_MAX / 2 + WIN_W - 1);
            y_start     <= YW'(Y_MAX / 2);
            y_end       <= YW'(Y_MAX / 2 + WIN_H - 1);
        end else begin
            vs_d        <= vs_in;
            update_done <= state == COMMIT;
            sx          <= sx_nxt;
            sy          <= sy_nxt;
            if (state == COMMIT) begin
                state   <= IDLE;
                x_start <= sx;
                x_end   <= sx + XW'(WIN_W - 1);
                y_start <= sy;
                y_end   <= sy + YW'(WIN_H - 1);
            end else begin
                state <= (state == PEND && vs_rise) ? COMMIT :
                         (cfg_acc | x_req | y_req) ? PEND : state;
            end
        end
    end
endmodule

// File: tb/tb_crop_win_ctrl.sv
// tb_crop_win_ctrl: scoreboard bench for crop_win_ctrl; expected windows queued at stimulus, popped on update_done
module tb_crop_win_ctrl;
    logic        clk = 0, rst_n = 0, vs_in = 0;
    logic        pan_left = 0, pan_right = 0, pan_up = 0, pan_down = 0;
    logic        cfg_valid = 0;
    logic [10:0] cfg_x = 0;
    logic [9:0]  cfg_y = 0;
    logic        cfg_ready, pending, update_done;
    logic [10:0] x_start, x_end;
    logic [9:0]  y_start, y_end;
    logic [41:0] exp_q[$];
    int tests = 0, failed = 0, pushed = 0, seen = 0;

    crop_win_ctrl dut (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in),
        .pan_left(pan_left), .pan_right(pan_right), .pan_up(pan_up), .pan_down(pan_down),
        .cfg_valid(cfg_valid), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_ready(cfg_ready),
        .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
        .pending(pending), .update_done(update_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int xs, input int ys);
        exp_q.push_back({11'(xs), 11'(xs + 959), 10'(ys), 10'(ys + 539)});
        pushed++;
    endtask

    task automatic cfg(input int x, input int y);
        cfg_valid = 1; cfg_x = 11'(x); cfg_y = 10'(y);
        cyc(1);
        cfg_valid = 0;
    endtask

    task automatic frame();
        vs_in = 1;
        cyc(3);
        vs_in = 0;
        cyc(2);
    endtask

    task automatic check_win(input string name, input int xs, input int ys);
        check({name, ".x_start"}, x_start, xs);
        check({name, ".x_end"}, x_end, xs + 959);
        check({name, ".y_start"}, y_start, ys);
        check({name, ".y_end"}, y_end, ys + 539);
    endtask

    function automatic int mstep(input int cur, input int mx, input bit up);
        int n;
        n = up ? cur + 16 : cur - 16;
`ifdef CROP_WIN_CTRL_WRAP_EN
        return n > mx ? 0 : (n < 0 ? mx : n);
`else
        return n > mx ? mx : (n < 0 ? 0 : n);
`endif
    endfunction

    // monitor: every update_done cycle must match the oldest queued window
    always @(negedge clk) begin
        if (rst_n && update_done) begin
            seen++;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL monitor: unexpected update_done at x=%0d y=%0d", x_start, y_start);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if ({x_start, x_end, y_start, y_end} != e) begin
                    failed++;
                    $display("FAIL monitor: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                             x_start, x_end, y_start, y_end, e[41:31], e[30:20], e[19:10], e[9:0]);
                end
            end
        end
    end

    initial begin
        int ex, ey;
        #12;
        check_win("reset", 160, 90);
        check("reset.pending", pending, 0);
        check("reset.update_done", update_done, 0);
        check("reset.cfg_ready", cfg_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        cyc(2);

        // pan right, commit latency of two edges from vsync
        pan_right = 1; cyc(1); pan_right = 0;
        check("pan.pending", pending, 1);
        check_win("pan.unchanged", 160, 90);
        push(176, 90);
        vs_in = 1;
        cyc(1);
        check("commit.cfg_ready", cfg_ready, 0);
        check("commit.x_hold", x_start, 160);
        cyc(1);
        check_win("latency", 176, 90);
        cyc(1); vs_in = 0; cyc(2);
        check("idle.pending", pending, 0);

        // cfg clamping
        cfg(500, 50);
        push(320, 50);
        frame();
        check_win("clamp", 320, 50);

        // bounds: 21 right pans within one frame, 6 up pans
        cfg(160, 90); push(160, 90); frame();
        ex = 160; ey = 90;
        for (int i = 0; i < 21; i++) begin
            pan_right = 1; cyc(1); pan_right = 0;
            ex = mstep(ex, 320, 1);
        end
        for (int i = 0; i < 6; i++) begin
            pan_up = 1; cyc(1); pan_up = 0;
            ey = mstep(ey, 180, 0);
        end
        push(ex, ey);
        frame();
`ifndef CROP_WIN_CTRL_WRAP_EN
        check("bound.x_sat", x_start, 320);
        check("bound.y_sat", y_start, 0);
`endif

        // cfg wins over a same-cycle pan
        cfg_valid = 1; cfg_x = 100; cfg_y = 100; pan_up = 1;
        cyc(1);
        cfg_valid = 0; pan_up = 0;
        push(100, 100);
        frame();
        check_win("cfg_prio", 100, 100);

        // opposite pans cancel, then vsync in IDLE changes nothing
        pan_left = 1; pan_right = 1; cyc(1); pan_left = 0; pan_right = 0;
        check("cancel.pending", pending, 0);
        frame();
        check_win("idle_vs", 100, 100);

        // PEND overwrite
        cfg(10, 20); cfg(30, 40);
        push(30, 40);
        frame();
        check_win("overwrite", 30, 40);

        // reset while in COMMIT discards the staged move
        pan_down = 1; cyc(1); pan_down = 0;
        vs_in = 1; cyc(1);
        check("rstc.pending_before", pending, 1);
        rst_n = 0; vs_in = 0;
        #2;
        check_win("rstc", 160, 90);
        check("rstc.pending", pending, 0);
        check("rstc.update_done", update_done, 0);
        cyc(1); rst_n = 1;
        cyc(4);
        check_win("rstc.after", 160, 90);

        check("queue_empty", exp_q.size(), 0);
        check("update_count", seen, pushed);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
